// File: rtl/lif_spike_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_spike_monitor_if
// Description : Voltage input, spike-record read port and status signals
//               of the LIF spike monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_spike_monitor_if #(
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        v_in;
    logic               v_valid;
    logic               spike;
    logic [TS_W-1:0]    ts_data;
    logic [TS_W-1:0]    isi_data;
    logic               ts_valid;
    logic               ts_ready;
    logic [c_CNT_W-1:0] fifo_count;
    logic [15:0]        rate;
    logic               rate_valid;
    logic               overflow;

    modport master (
        output v_in, v_valid, ts_ready,
        input  spike, ts_data, isi_data, ts_valid, fifo_count, rate, rate_valid, overflow
    );

    modport slave (
        input  v_in, v_valid, ts_ready,
        output spike, ts_data, isi_data, ts_valid, fifo_count, rate, rate_valid, overflow
    );
endinterface
`default_nettype wire

// File: rtl/lif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lif_spike_monitor
// Description : Detects LIF spikes (armed sample followed by zero), queues
//               {timestamp, ISI} records and reports a windowed spike rate.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_spike_monitor #(
    parameter logic signed [31:0] ARM_LEVEL  = 32'sh0000_8000,
    parameter int                 WINDOW     = 256,
    parameter int                 FIFO_DEPTH = 8,
    parameter int                 TS_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lif_spike_monitor_if.slave bus
);
    localparam int                 c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [15:0]        c_WIN_LAST = 16'(WINDOW - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);

    logic signed [31:0]  prev_v_q, prev_v_d;
    logic [TS_W-1:0]     step_q, step_d;
    logic [TS_W-1:0]     last_ts_q, last_ts_d;
    logic                first_q, first_d;
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic                spike_q, spike_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         win_cnt_q, win_cnt_d;
    logic [15:0]         spk_cnt_q, spk_cnt_d;
    logic [15:0]         rate_q, rate_d;
    logic                rate_valid_q, rate_valid_d;
    logic [TS_W-1:0]     mem_ts_q  [FIFO_DEPTH];
    logic [TS_W-1:0]     mem_isi_q [FIFO_DEPTH];

    logic                w_spike;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [TS_W-1:0]     w_isi;
    logic [15:0]         w_spk_inc;

    assign w_spike   = bus.v_valid && (prev_v_q > ARM_LEVEL) && (bus.v_in == 32'd0);
    assign w_isi     = first_q ? '0 : (step_q - last_ts_q);
    assign w_full    = (count_q == c_FULL);
    assign w_pop     = bus.ts_ready && (count_q != '0);
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign w_push    = w_spike && (!w_full || w_pop);
    assign w_spk_inc = (spk_cnt_q == 16'hFFFF) ? spk_cnt_q : (spk_cnt_q + 16'(w_spike));

    always_comb begin
        prev_v_d     = prev_v_q;
        step_d       = step_q;
        last_ts_d    = last_ts_q;
        first_d      = first_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        win_cnt_d    = win_cnt_q;
        spk_cnt_d    = spk_cnt_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        spike_d      = w_spike;
        count_d      = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        if (bus.v_valid) begin
            prev_v_d = bus.v_in;
            step_d   = step_q + TS_W'(1);
            if (win_cnt_q == c_WIN_LAST) begin
                rate_d       = w_spk_inc;
                rate_valid_d = 1'b1;
                win_cnt_d    = '0;
                spk_cnt_d    = '0;
            end else begin
                win_cnt_d = win_cnt_q + 16'(1);
                spk_cnt_d = w_spk_inc;
            end
        end

        if (w_spike) begin
            last_ts_d = step_q;
            first_d   = 1'b0;
            if (!w_push) begin
                overflow_d = 1'b1;
            end
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_v_q     <= '0;
            step_q       <= '0;
            last_ts_q    <= '0;
            first_q      <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            spike_q      <= 1'b0;
            overflow_q   <= 1'b0;
            win_cnt_q    <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            prev_v_q     <= prev_v_d;
            step_q       <= step_d;
            last_ts_q    <= last_ts_d;
            first_q      <= first_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            spike_q      <= spike_d;
            overflow_q   <= overflow_d;
            win_cnt_q    <= win_cnt_d;
            spk_cnt_q    <= spk_cnt_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    // Record storage needs no reset; contents are only visible through count_q
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_ts_q[wr_ptr_q]  <= step_q;
            mem_isi_q[wr_ptr_q] <= w_isi;
        end
    end

    assign bus.spike      = spike_q;
    assign bus.ts_data    = mem_ts_q[rd_ptr_q];
    assign bus.isi_data   = mem_isi_q[rd_ptr_q];
    assign bus.ts_valid   = (count_q != '0);
    assign bus.fifo_count = count_q;
    assign bus.rate       = rate_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.overflow   = overflow_q;
endmodule
`default_nettype wire

// File: doc/lif_spike_monitor.md
# lif_spike_monitor

Downstream consumer of the LIF neuron's membrane-voltage output. It samples the Q16.16 voltage once per neuron update and detects spikes, which are threshold crossings followed by a reset of the membrane to zero. For each spike it stamps the time step and the inter-spike interval (ISI) into a small FIFO with a valid/ready read port. It also reports a windowed spike-rate count for the host/readout logic.

## Interface
- ARM_LEVEL, 32'h00008000 (0.5 in Q16.16): previous sample must exceed this for a zero sample to count as a spike
- WINDOW, 256: rate window length in valid samples; range 2..65535
- FIFO_DEPTH, 8: spike-record FIFO depth; power of two, ≥2
- TS_W, 16: timestamp and ISI width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- v_in  input  32  signed Q16.16 membrane voltage (neuron VOUT)
- v_valid  input  1  one-cycle strobe: v_in holds a new neuron update
- spike  output  1  one-cycle pulse per detected spike
- ts_data  output  TS_W  timestamp of FIFO head record
- isi_data  output  TS_W  ISI of FIFO head record
- ts_valid  output  1  FIFO non-empty
- ts_ready  input  1  consumer pops head when ts_valid && ts_ready
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
- rate  output  16  spikes counted in last completed window
- rate_valid  output  1  one-cycle pulse when rate updates
- overflow  output  1  sticky: a spike was dropped because FIFO was full

## Operation
- Reset (rst=1 at an edge): spike=0, ts_valid=0, fifo_count=0, rate=0, rate_valid=0, overflow=0. Internal state cleared: prev_v=0, step counter=0, last_ts=0, first_spike flag set, window counters=0. Reset mid-operation discards all FIFO contents and any partial window.
- Samples with v_valid=0 are ignored entirely.
- On each v_valid cycle:
  - Spike condition: prev_v > ARM_LEVEL (signed compare) and v_in == 0.
  - prev_v <= v_in.
  - step <= step+1, modulo 2^TS_W.
- On a spike:
  - Timestamp = step value before increment.
  - ISI = timestamp − last_ts, modulo 2^TS_W. ISI = 0 for the first spike after reset.
  - last_ts <= timestamp; first_spike flag cleared.
  - Record {timestamp, ISI} pushed if FIFO not full.
  - If the FIFO is full and no pop occurs in the same cycle, the record is dropped and overflow is set. overflow clears only on rst.
  - spike pulses regardless of whether the record is pushed or dropped.
- Negative or sub-ARM_LEVEL samples followed by 0 are not spikes. Consecutive zeros produce no spike, because prev_v=0.
- FIFO: circular buffer with registered read and write pointers.
  - Push and pop in the same cycle when full: both accepted, count unchanged.
  - Push and pop in the same cycle when empty: pop is ignored (ts_valid=0) and the push is accepted.
  - Pop while empty has no effect.
  - ts_data/isi_data are undefined-but-stable when ts_valid=0.
- Rate window:
  - win_cnt counts valid samples and spk_cnt counts spikes.
  - On the valid sample where win_cnt == WINDOW−1, rate <= spk_cnt plus this sample's spike, rate_valid pulses, and both counters clear.
  - spk_cnt saturates at 16'hFFFF.
- Arithmetic: all comparisons are signed 32-bit; timestamp and ISI arithmetic is unsigned TS_W-bit wrap.

## Timing
- spike and rate_valid are registered, asserted in the cycle after the v_valid edge that produced them. Each is high for exactly one cycle.
- A pushed record raises ts_valid and updates fifo_count in that same cycle after the push, so ts_valid rises together with spike.
- A pop at edge N: head advances and fifo_count decrements in the cycle after N.
- Back-to-back v_valid every cycle is supported, with full throughput.
- Upstream neuron update period (4 clocks) is not assumed.

## Test plan
- Basic spike:
  - Stimulus: reset, then valid samples 0x4000, 0xC000, 0x0000.
  - Required: spike one cycle after the third sample; record ts=2, isi=0; ts_valid=1; fifo_count=1.
- No false spikes:
  - Stimulus: samples 0x4000→0 (below ARM_LEVEL), 0xFFFF0000 (−1)→0, then 0→0.
  - Required: no spike; FIFO empty.
- ISI and wrap:
  - Stimulus: TS_W=4; spikes at steps 3 and 17.
  - Required: records (3,0) and (1,14); ISI wraps modulo 16.
- FIFO full/overflow:
  - Stimulus: 9 spikes with ts_ready=0.
  - Required: fifo_count=8 and overflow=1 after the 9th.
  - Then a 10th spike coinciding with a pop: accepted, count stays 8.
  - Draining yields timestamps in order, excluding the 9th.
- Rate window:
  - Stimulus: WINDOW=16; 3 spikes in samples 0..15, the last spike on sample 15.
  - Required: rate=3 and rate_valid pulse after sample 15.
  - Next window with 0 spikes: rate=0.
- Reset mid-operation:
  - Stimulus: assert rst with 4 records queued and a partial window.
  - Required: next cycle ts_valid=0, fifo_count=0, overflow=0, rate=0; the first spike after release has ISI=0 and ts counted from 0.
